rate_tracker: RTL and testbench

- Rate-measurement stage wrapped around the lockin stage.
- Counts clk_en cycles between filtered edges and supplies that count to lockin as the rate accumulator.
- Holds the active bit rate and latches the loop-back drift direction, updating both from lockin's update_rate / clear_rate / drift outputs.
- Sequences acquisition, tracking and timeout, and drives lockin_en / clear_state into lockin.

---
 rtl/rate_tracker.sv | 166 ++++++++++++++++
 tb/tb_rate_tracker.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rate_tracker.sv
// Rate-measurement stage around lockin: counts clk_en cycles between filtered edges,
// holds the active bit rate and drift direction, and sequences acquire/track/timeout.
package rate_tracker_pkg;
    typedef enum logic {
        PIN_CAME_LATE  = 1'b0,
        PIN_CAME_EARLY = 1'b1
    } drift_direction_e;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACQUIRE = 2'd1,
        MEASURE = 2'd2,
        TRACK   = 2'd3
    } rt_state_e;
endpackage

module rate_tracker
    import rate_tracker_pkg::*;
#(
    parameter int RATE_COUNTER_WIDTH = 16,
    parameter int MIN_RATE           = 2
) (
    input  logic                          clk,
    input  logic                          sync_rst_n,
    input  logic                          clk_en,
    input  logic                          enable_i,
    input  logic                          clear_state_i,
    input  logic [RATE_COUNTER_WIDTH-1:0] timeout_limit_i,
    input  logic                          filtered_event_i,
    input  logic                          update_rate_i,
    input  logic                          clear_rate_i,
    input  logic                          drift_detected_i,
    input  drift_direction_e              drift_direction_i,
    output logic [RATE_COUNTER_WIDTH-1:0] rate_accumulator_o,
    output logic [RATE_COUNTER_WIDTH-1:0] active_rate_o,
    output logic                          active_rate_valid_o,
    output drift_direction_e              active_drift_direction_o,
    output logic                          drift_latched_o,
    output logic                          lockin_en_o,
    output logic                          lockin_clear_o,
    output logic                          glitch_o,
    output logic                          timeout_o,
    output rt_state_e                     dbg_state_o
);
    localparam int W = RATE_COUNTER_WIDTH;
    localparam logic [W-1:0] ACC_MAX    = {W{1'b1}};
    localparam logic [W-1:0] ACC_ONE    = W'(1);
    localparam logic [W-1:0] MIN_RATE_W = W'(MIN_RATE);

    rt_state_e        r_state;
    logic [W-1:0]     r_acc;
    logic [W-1:0]     r_rate;
    logic             r_valid;
    drift_direction_e r_dir;
    logic             r_latched;
    logic             r_lockin_en;

    rt_state_e        w_state_nxt;
    logic [W-1:0]     w_acc_nxt;
    logic [W-1:0]     w_rate_nxt;
    logic             w_valid_nxt;
    drift_direction_e w_dir_nxt;
    logic             w_latched_nxt;
    logic             w_leave;
    logic             w_glitch;
    logic             w_timeout;
    logic             w_busy;
    logic             w_expired;
    logic             w_run;
    logic [W-1:0]     w_acc_inc;

    assign w_busy    = (r_state == MEASURE) || (r_state == TRACK);
    assign w_expired = (timeout_limit_i != '0) && (r_acc >= timeout_limit_i);
    assign w_acc_inc = (r_acc == ACC_MAX) ? r_acc : r_acc + ACC_ONE;
    assign w_run     = clk_en && sync_rst_n;

    // Priority: disable > software clear > timeout > update / clear_rate.
    always_comb begin
        w_state_nxt   = r_state;
        w_acc_nxt     = r_acc;
        w_rate_nxt    = r_rate;
        w_valid_nxt   = r_valid;
        w_dir_nxt     = r_dir;
        w_latched_nxt = r_latched;
        w_leave       = 1'b0;
        w_glitch      = 1'b0;
        w_timeout     = 1'b0;
        if (!enable_i) begin
            w_state_nxt = IDLE;
            w_acc_nxt   = '0;
            w_leave     = w_busy;
        end else if (clear_state_i && (r_state != IDLE)) begin
            w_state_nxt = ACQUIRE;
            w_acc_nxt   = '0;
            w_leave     = w_busy;
        end else if (w_busy && w_expired) begin
            w_state_nxt = ACQUIRE;
            w_acc_nxt   = '0;
            w_leave     = 1'b1;
            w_timeout   = 1'b1;
        end else begin
            case (r_state)
                IDLE: w_state_nxt = ACQUIRE;
                ACQUIRE: begin
                    if (filtered_event_i) begin
                        w_state_nxt = MEASURE;
                        w_acc_nxt   = '0;
                    end
                end
                default: begin
                    // Update samples the pre-clear count; the clear lands afterwards.
                    w_acc_nxt = clear_rate_i ? '0 : w_acc_inc;
                    if (update_rate_i) begin
                        if (r_acc < MIN_RATE_W) begin
                            w_glitch = 1'b1;
                        end else begin
                            w_rate_nxt  = r_acc;
                            w_valid_nxt = 1'b1;
                            w_state_nxt = TRACK;
                            if ((r_state == TRACK) && drift_detected_i && !r_latched) begin
                                w_latched_nxt = 1'b1;
                                w_dir_nxt     = drift_direction_i;
                            end
                        end
                    end
                end
            endcase
        end
        if (w_leave) begin
            w_valid_nxt   = 1'b0;
            w_latched_nxt = 1'b0;
            w_dir_nxt     = PIN_CAME_LATE;
        end
    end

    always_ff @(posedge clk) begin
        if (!sync_rst_n) begin
            r_state     <= IDLE;
            r_acc       <= '0;
            r_rate      <= '0;
            r_valid     <= 1'b0;
            r_dir       <= PIN_CAME_LATE;
            r_latched   <= 1'b0;
            r_lockin_en <= 1'b0;
        end else if (clk_en) begin
            r_state     <= w_state_nxt;
            r_acc       <= w_acc_nxt;
            r_rate      <= w_rate_nxt;
            r_valid     <= w_valid_nxt;
            r_dir       <= w_dir_nxt;
            r_latched   <= w_latched_nxt;
            r_lockin_en <= (w_state_nxt == TRACK);
        end
    end

    assign rate_accumulator_o       = r_acc;
    assign active_rate_o            = r_rate;
    assign active_rate_valid_o      = r_valid;
    assign active_drift_direction_o = r_dir;
    assign drift_latched_o          = r_latched;
    assign lockin_en_o              = r_lockin_en;
    assign lockin_clear_o           = w_run && w_leave;
    assign glitch_o                 = w_run && w_glitch;
    assign timeout_o                = w_run && w_timeout;
    assign dbg_state_o              = r_state;
endmodule

// File: tb/tb_rate_tracker.sv
// Bench for rate_tracker: directed scenarios plus randomized traffic, all checked
// cycle by cycle against a behavioural model of the rate/drift/timeout rules.
module tb_rate_tracker;
    import rate_tracker_pkg::*;

    localparam int W    = 8;
    localparam int MAXV = (1 << W) - 1;
    localparam int MINR = 2;
    localparam int VW   = 2 * W + 9;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             b_rst_n = 1'b0;
    logic             b_clk_en = 1'b1;
    logic             b_enable = 1'b0;
    logic             b_clear_state = 1'b0;
    logic [W-1:0]     b_tlim = '0;
    logic             b_event = 1'b0;
    logic             b_update = 1'b0;
    logic             b_clear_rate = 1'b0;
    logic             b_drift = 1'b0;
    drift_direction_e b_dir = PIN_CAME_LATE;

    logic [W-1:0]     acc_o, rate_o;
    logic             valid_o, lat_o, len_o, lclr_o, glitch_o, tmo_o;
    drift_direction_e dir_o;
    rt_state_e        st_o;

    rate_tracker #(.RATE_COUNTER_WIDTH(W), .MIN_RATE(MINR)) dut (
        .clk(clk), .sync_rst_n(b_rst_n), .clk_en(b_clk_en), .enable_i(b_enable),
        .clear_state_i(b_clear_state), .timeout_limit_i(b_tlim),
        .filtered_event_i(b_event), .update_rate_i(b_update), .clear_rate_i(b_clear_rate),
        .drift_detected_i(b_drift), .drift_direction_i(b_dir),
        .rate_accumulator_o(acc_o), .active_rate_o(rate_o), .active_rate_valid_o(valid_o),
        .active_drift_direction_o(dir_o), .drift_latched_o(lat_o), .lockin_en_o(len_o),
        .lockin_clear_o(lclr_o), .glitch_o(glitch_o), .timeout_o(tmo_o), .dbg_state_o(st_o)
    );

    logic [VW-1:0] dut_vec;
    assign dut_vec = {st_o, acc_o, rate_o, valid_o, dir_o, lat_o, len_o, lclr_o, glitch_o, tmo_o};

    int total = 0;
    int bad   = 0;

    // Behavioural model state and the pulses expected in the current cycle
    rt_state_e        m_state = IDLE, n_state;
    int               m_acc = 0, m_rate = 0, n_acc, n_rate;
    bit               m_valid = 0, m_lat = 0, n_valid, n_lat;
    drift_direction_e m_dir = PIN_CAME_LATE, n_dir;
    bit               e_glitch, e_timeout, e_lclear;

    task automatic model_eval();
        bit busy, tmo, leave;
        n_state = m_state; n_acc = m_acc; n_rate = m_rate;
        n_valid = m_valid; n_lat = m_lat; n_dir = m_dir;
        e_glitch = 0; e_timeout = 0; e_lclear = 0;
        if (!b_rst_n) begin
            n_state = IDLE; n_acc = 0; n_rate = 0; n_valid = 0; n_lat = 0; n_dir = PIN_CAME_LATE;
        end else if (b_clk_en) begin
            busy  = (m_state == MEASURE) || (m_state == TRACK);
            tmo   = busy && (b_tlim != 0) && (m_acc >= int'(b_tlim));
            leave = 0;
            if (!b_enable) begin
                n_state = IDLE; n_acc = 0; leave = busy;
            end else if (b_clear_state && m_state != IDLE) begin
                n_state = ACQUIRE; n_acc = 0; leave = busy;
            end else if (tmo) begin
                n_state = ACQUIRE; n_acc = 0; leave = 1; e_timeout = 1;
            end else if (m_state == IDLE) begin
                n_state = ACQUIRE;
            end else if (m_state == ACQUIRE) begin
                if (b_event) begin n_state = MEASURE; n_acc = 0; end
            end else begin
                n_acc = b_clear_rate ? 0 : ((m_acc + 1 > MAXV) ? MAXV : m_acc + 1);
                if (b_update && m_acc < MINR) e_glitch = 1;
                else if (b_update) begin
                    n_rate = m_acc; n_valid = 1;
                    if (m_state == TRACK && b_drift && !m_lat) begin n_lat = 1; n_dir = b_dir; end
                    n_state = TRACK;
                end
            end
            if (leave) begin
                n_valid = 0; n_lat = 0; n_dir = PIN_CAME_LATE; e_lclear = 1;
            end
        end
    endtask

    function automatic logic [VW-1:0] exp_vec();
        return {m_state, m_acc[W-1:0], m_rate[W-1:0], m_valid, m_dir, m_lat,
                m_state == TRACK, e_lclear, e_glitch, e_timeout};
    endfunction

    task automatic settle();
        @(negedge clk);
        model_eval();
    endtask

    task automatic sync_edge();
        m_state = n_state; m_acc = n_acc; m_rate = n_rate;
        m_valid = n_valid; m_lat = n_lat; m_dir = n_dir;
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        b_clk_en = 1; b_clear_state = 0; b_event = 0; b_update = 0;
        b_clear_rate = 0; b_drift = 0; b_dir = PIN_CAME_LATE;
    endtask

    task automatic test_reset();
        logic [VW-1:0] rst_vec;
        rst_vec = {IDLE, {W{1'b0}}, {W{1'b0}}, 1'b0, PIN_CAME_LATE, 6'b0};
        b_rst_n = 0; b_enable = 1; b_clear_state = 1; b_event = 1; b_update = 1;
        b_clear_rate = 1; b_drift = 1; b_dir = PIN_CAME_EARLY; b_tlim = 8'd1;
        for (int c = 0; c < 3; c++) begin
            settle();
            if (c > 0) begin
                if (dut_vec !== rst_vec) begin
                    bad++; $display("FAIL reset_values c=%0d got=%h exp=%h", c, dut_vec, rst_vec);
                end
                total++;
            end
            sync_edge();
        end
        b_rst_n = 1; b_enable = 0; b_tlim = '0; quiet();
        for (int c = 0; c < 2; c++) begin
            if (c == 1) b_enable = 1;
            settle();
            if (dut_vec !== exp_vec()) begin
                bad++; $display("FAIL reset_release c=%0d got=%h exp=%h", c, dut_vec, exp_vec());
            end
            total++;
            sync_edge();
        end
        if (st_o !== ACQUIRE || valid_o !== 1'b0 || acc_o !== 8'd0 || rate_o !== 8'd0 || len_o !== 1'b0) begin
            bad++; $display("FAIL enable_acquire got st=%0d v=%b acc=%0d rate=%0d len=%b exp st=1 v=0 acc=0 rate=0 len=0",
                            st_o, valid_o, acc_o, rate_o, len_o);
        end
        total++;
    endtask

    // Events with update+clear_rate every 11 cycles: 10 clk_en cycles counted in between
    task automatic test_track();
        for (int c = 0; c <= 22; c++) begin
            quiet();
            b_event = (c % 11 == 0); b_update = b_event; b_clear_rate = b_event;
            settle();
            if (c == 11 && acc_o !== 8'd10) begin
                bad++; $display("FAIL track_acc_at_event got=%0d exp=10", acc_o);
            end
            if (c == 11) total++;
            if (dut_vec !== exp_vec()) begin
                bad++; $display("FAIL track_cycle c=%0d got=%h exp=%h", c, dut_vec, exp_vec());
            end
            total++;
            sync_edge();
        end
        if (rate_o !== 8'd10 || valid_o !== 1'b1 || len_o !== 1'b1) begin
            bad++; $display("FAIL track_lock got rate=%0d v=%b len=%b exp rate=10 v=1 len=1", rate_o, valid_o, len_o);
        end
        total++;
    endtask

    task automatic test_glitch();
        for (int c = 0; c < 3; c++) begin
            quiet();
            b_event = (c == 1); b_update = b_event; b_clear_rate = b_event;
            settle();
            if (c == 1) begin
                if (glitch_o !== 1'b1 || acc_o !== 8'd1) begin
                    bad++; $display("FAIL glitch_pulse got glitch=%b acc=%0d exp glitch=1 acc=1", glitch_o, acc_o);
                end
                total++;
            end
            if (dut_vec !== exp_vec()) begin
                bad++; $display("FAIL glitch_cycle c=%0d got=%h exp=%h", c, dut_vec, exp_vec());
            end
            total++;
            sync_edge();
        end
        if (rate_o !== 8'd10 || valid_o !== 1'b1) begin
            bad++; $display("FAIL glitch_rate_kept got rate=%0d v=%b exp rate=10 v=1", rate_o, valid_o);
        end
        total++;
    endtask

    task automatic test_drift();
        // glitch test leaves acc at 1 after its last quiet cycle
        for (int c = 0; c < 20; c++) begin
            quiet();
            b_event = (c == 8 || c == 18); b_update = b_event; b_clear_rate = b_event;
            b_drift = b_event; b_dir = (c == 8) ? PIN_CAME_EARLY : PIN_CAME_LATE;
            settle();
            if (dut_vec !== exp_vec()) begin
                bad++; $display("FAIL drift_cycle c=%0d got=%h exp=%h", c, dut_vec, exp_vec());
            end
            total++;
            sync_edge();
            if (c == 8) begin
                if (dir_o !== PIN_CAME_EARLY || lat_o !== 1'b1 || rate_o !== 8'd9) begin
                    bad++; $display("FAIL drift_latch got dir=%0d lat=%b rate=%0d exp dir=1 lat=1 rate=9", dir_o, lat_o, rate_o);
                end
                total++;
            end
        end
        if (dir_o !== PIN_CAME_EARLY || lat_o !== 1'b1 || rate_o !== 8'd9) begin
            bad++; $display("FAIL drift_hold got dir=%0d lat=%b rate=%0d exp dir=1 lat=1 rate=9", dir_o, lat_o, rate_o);
        end
        total++;
    endtask

    task automatic test_timeout();
        int n_tmo = 0, n_clr = 0, acc_at = -1;
        quiet(); b_tlim = 8'd50;
        for (int c = 0; c < 70; c++) begin
            settle();
            if (tmo_o === 1'b1) begin n_tmo++; acc_at = int'(acc_o); end
            if (lclr_o === 1'b1) n_clr++;
            if (dut_vec !== exp_vec()) begin
                bad++; $display("FAIL timeout_cycle c=%0d got=%h exp=%h", c, dut_vec, exp_vec());
            end
            total++;
            sync_edge();
        end
        if (n_tmo != 1 || acc_at != 50 || n_clr != 1) begin
            bad++; $display("FAIL timeout_fire got pulses=%0d acc=%0d clears=%0d exp pulses=1 acc=50 clears=1", n_tmo, acc_at, n_clr);
        end
        total++;
        if (st_o !== ACQUIRE || valid_o !== 1'b0 || lat_o !== 1'b0 || dir_o !== PIN_CAME_LATE) begin
            bad++; $display("FAIL timeout_state got st=%0d v=%b lat=%b dir=%0d exp st=1 v=0 lat=0 dir=0", st_o, valid_o, lat_o, dir_o);
        end
        total++;
        b_tlim = '0;
    endtask

    // clk_en high every other cycle; events 22 raw cycles apart -> 10 enabled cycles
    task automatic test_clk_en();
        for (int r = 0; r <= 66; r++) begin
            quiet();
            b_clk_en = (r % 2 == 0);
            b_event = (r % 22 == 0); b_update = b_event; b_clear_rate = b_event;
            if (r == 11) begin b_update = 1; b_clear_rate = 1; b_clear_state = 1; end
            settle();
            if (dut_vec !== exp_vec()) begin
                bad++; $display("FAIL clk_en_cycle r=%0d got=%h exp=%h", r, dut_vec, exp_vec());
            end
            total++;
            sync_edge();
        end
        if (rate_o !== 8'd10 || len_o !== 1'b1) begin
            bad++; $display("FAIL clk_en_rate got rate=%0d len=%b exp rate=10 len=1", rate_o, len_o);
        end
        total++;
    endtask

    task automatic test_clear_state();
        for (int c = 0; c < 8; c++) begin
            quiet();
            if (c == 5 || c == 7) begin
                b_clear_state = 1; b_event = 1; b_update = 1; b_clear_rate = 1;
            end
            settle();
            if (c == 5) begin
                if (lclr_o !== 1'b1 || glitch_o !== 1'b0) begin
                    bad++; $display("FAIL clear_state_pulse got lclr=%b glitch=%b exp lclr=1 glitch=0", lclr_o, glitch_o);
                end
                total++;
            end
            if (dut_vec !== exp_vec()) begin
                bad++; $display("FAIL clear_state_cycle c=%0d got=%h exp=%h", c, dut_vec, exp_vec());
            end
            total++;
            sync_edge();
            if (c == 5) begin
                if (st_o !== ACQUIRE || valid_o !== 1'b0 || rate_o !== 8'd10) begin
                    bad++; $display("FAIL clear_state_result got st=%0d v=%b rate=%0d exp st=1 v=0 rate=10", st_o, valid_o, rate_o);
                end
                total++;
            end
        end
    endtask

    task automatic test_disable();
        for (int c = 0; c < 6; c++) begin
            quiet();
            b_event = (c == 0 || c == 3); b_update = b_event; b_clear_rate = b_event;
            b_enable = (c != 4);
            settle();
            if (dut_vec !== exp_vec()) begin
                bad++; $display("FAIL disable_cycle c=%0d got=%h exp=%h", c, dut_vec, exp_vec());
            end
            total++;
            sync_edge();
            if (c == 3 && (rate_o !== 8'd2 || st_o !== TRACK)) begin
                bad++; $display("FAIL min_rate_accept got rate=%0d st=%0d exp rate=2 st=3", rate_o, st_o);
            end
            if (c == 3) total++;
            if (c == 4 && (st_o !== IDLE || valid_o !== 1'b0 || len_o !== 1'b0)) begin
                bad++; $display("FAIL disable_idle got st=%0d v=%b len=%b exp st=0 v=0 len=0", st_o, valid_o, len_o);
            end
            if (c == 4) total++;
        end
    endtask

    task automatic test_saturation();
        for (int c = 0; c <= 265; c++) begin
            quiet();
            b_event = (c == 1 || c == 264); b_update = (c == 264); b_clear_rate = b_update;
            settle();
            if (c == 263 && acc_o !== 8'd255) begin
                bad++; $display("FAIL acc_saturate got=%0d exp=255", acc_o);
            end
            if (c == 263) total++;
            if (dut_vec !== exp_vec()) begin
                bad++; $display("FAIL saturation_cycle c=%0d got=%h exp=%h", c, dut_vec, exp_vec());
            end
            total++;
            sync_edge();
        end
        if (rate_o !== 8'd255 || valid_o !== 1'b1) begin
            bad++; $display("FAIL saturation_rate got rate=%0d v=%b exp rate=255 v=1", rate_o, valid_o);
        end
        total++;
    endtask

    task automatic test_random();
        for (int c = 0; c < 1500; c++) begin
            if (c % 200 == 0) b_tlim = ($urandom_range(0, 2) == 0) ? 8'd0 : 8'($urandom_range(15, 60));
            b_rst_n       = ($urandom_range(0, 499) != 0);
            b_clk_en      = ($urandom_range(0, 3) != 0);
            b_enable      = ($urandom_range(0, 79) != 0);
            b_clear_state = ($urandom_range(0, 59) == 0);
            b_event       = ($urandom_range(0, 5) == 0);
            b_update      = b_event ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 40) == 0);
            b_clear_rate  = b_update ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 30) == 0);
            b_drift       = ($urandom_range(0, 2) == 0);
            b_dir         = drift_direction_e'($urandom_range(0, 1));
            settle();
            if (dut_vec !== exp_vec()) begin
                bad++; $display("FAIL random_cycle c=%0d got=%h exp=%h", c, dut_vec, exp_vec());
            end
            total++;
            sync_edge();
        end
    endtask

    initial begin
        test_reset();
        test_track();
        test_glitch();
        test_drift();
        test_timeout();
        test_clk_en();
        test_clear_state();
        test_disable();
        test_saturation();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1);
    end
endmodule
